imem_responder: RTL and testbench



---
 rtl/imem_responder_pkg.sv | 18 +
 rtl/imem_responder_if.sv | 25 ++
 rtl/imem_responder_array.sv | 25 ++
 rtl/imem_responder.sv | 102 ++++++++++
 tb/tb_imem_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the fetch FSM state encoding and the PC alignment helper.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fetch_state_t;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] ERR_INST = 32'h0;

  function automatic logic is_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake between the fetch stage (master) and the responder (slave).
interface imem_responder_if;
  import rv_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_pc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [INST_W-1:0] rsp_inst;
  logic [31:0]       rsp_pc;
  logic              rsp_err;
  logic              flush;

  modport master (
    output req_valid, req_pc, rsp_ready, flush,
    input  req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_err
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready, flush,
    output req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_err
  );

endinterface

// File: rtl/imem_responder_array.sv
// Word-addressed instruction store: synchronous write, combinational read, never reset.
module imem_array
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [INST_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [INST_W-1:0]        rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch per handshake and answers after LATENCY wait states.
// Flush drops the in-flight fetch; the backdoor load port may write the array at any time.
module imem_responder
  import rv_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  imem_responder_if.slave          bus,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [INST_W-1:0]        ld_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  fetch_state_t      state;
  logic [CW-1:0]     wait_cnt;
  logic              rsp_valid_q;
  logic [INST_W-1:0] rsp_inst_q;
  logic [31:0]       rsp_pc_q;
  logic              rsp_err_q;

  logic              accept;
  logic              pc_err;
  logic [AW-1:0]     rd_idx;
  logic [INST_W-1:0] rd_data;

  assign bus.req_ready = !bus.flush && (state == IDLE || (state == RESP && bus.rsp_ready));
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_idx        = bus.req_pc[AW+1:2];

  // DEPTH is a power of two, so any set bit above the word index means out of range.
  assign pc_err = is_misaligned(bus.req_pc) || (bus.req_pc[31:AW+2] != '0);

  imem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ld_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // The array read is combinational, so capturing at accept sees the word before any same-edge load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_inst_q  <= ERR_INST;
      rsp_pc_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rsp_valid_q <= 1'b0;
    end else if (accept) begin
      rsp_inst_q <= pc_err ? ERR_INST : rd_data;
      rsp_pc_q   <= bus.req_pc;
      rsp_err_q  <= pc_err;
      if (LATENCY == 0) begin
        state       <= RESP;
        rsp_valid_q <= 1'b1;
      end else begin
        state       <= WAIT;
        wait_cnt    <= CW'(LATENCY - 1);
        rsp_valid_q <= 1'b0;
      end
    end else begin
      case (state)
        WAIT: begin
          if (wait_cnt == '0) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_inst  = rsp_inst_q;
  assign bus.rsp_pc    = rsp_pc_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 0, 2, 3; DEPTH 16) share one stimulus stream
// and are checked every cycle against a pending-response reference model.
module tb_imem_responder;

  localparam int N_DUT = 3;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          req_valid = 1'b0;
  logic [31:0]   req_pc    = '0;
  logic          rsp_ready = 1'b0;
  logic          flush     = 1'b0;
  logic          ld_en     = 1'b0;
  logic [AW-1:0] ld_addr   = '0;
  logic [31:0]   ld_data   = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_responder_if bus0 ();
  imem_responder_if bus1 ();
  imem_responder_if bus2 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_pc    = req_pc;
  assign bus0.rsp_ready = rsp_ready;
  assign bus0.flush     = flush;
  assign bus1.req_valid = req_valid;
  assign bus1.req_pc    = req_pc;
  assign bus1.rsp_ready = rsp_ready;
  assign bus1.flush     = flush;
  assign bus2.req_valid = req_valid;
  assign bus2.req_pc    = req_pc;
  assign bus2.rsp_ready = rsp_ready;
  assign bus2.flush     = flush;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
  imem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
  imem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  logic        o_ready [N_DUT];
  logic        o_valid [N_DUT];
  logic        o_err   [N_DUT];
  logic [31:0] o_inst  [N_DUT];
  logic [31:0] o_pc    [N_DUT];

  assign o_ready[0] = bus0.req_ready;
  assign o_valid[0] = bus0.rsp_valid;
  assign o_err[0]   = bus0.rsp_err;
  assign o_inst[0]  = bus0.rsp_inst;
  assign o_pc[0]    = bus0.rsp_pc;
  assign o_ready[1] = bus1.req_ready;
  assign o_valid[1] = bus1.rsp_valid;
  assign o_err[1]   = bus1.rsp_err;
  assign o_inst[1]  = bus1.rsp_inst;
  assign o_pc[1]    = bus1.rsp_pc;
  assign o_ready[2] = bus2.req_ready;
  assign o_valid[2] = bus2.rsp_valid;
  assign o_err[2]   = bus2.rsp_err;
  assign o_inst[2]  = bus2.rsp_inst;
  assign o_pc[2]    = bus2.rsp_pc;

  logic        obs_ready [N_DUT];
  logic        obs_valid [N_DUT];
  logic        obs_err   [N_DUT];
  logic [31:0] obs_inst  [N_DUT];
  logic [31:0] obs_pc    [N_DUT];

  // Reference model: each instance owes at most one response, due a fixed number of cycles after accept.
  logic [31:0] ref_mem [DEPTH];
  bit          pend    [N_DUT];
  int          due     [N_DUT];
  logic [31:0] m_inst  [N_DUT];
  logic [31:0] m_pc    [N_DUT];
  bit          m_err   [N_DUT];
  int          cyc = 0;

  function automatic int latOf(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit expValid(input int d);
    return pend[d] && (cyc >= due[d]);
  endfunction

  function automatic bit expReady(input int d);
    return !flush && (!pend[d] || (expValid(d) && rsp_ready));
  endfunction

  task automatic modelClear();
    for (int d = 0; d < N_DUT; d++) pend[d] = 1'b0;
  endtask

  task automatic modelUpdate();
    bit v;
    bit acc;
    bit err;
    for (int d = 0; d < N_DUT; d++) begin
      if (!rst_n) begin
        pend[d] = 1'b0;
      end else begin
        v   = expValid(d);
        acc = req_valid && expReady(d);
        if (flush) begin
          pend[d] = 1'b0;
        end else if (acc) begin
          err       = (req_pc[1:0] != 2'b00) || ((req_pc >> 2) >= 32'(DEPTH));
          pend[d]   = 1'b1;
          due[d]    = cyc + 1 + latOf(d);
          m_err[d]  = err;
          m_pc[d]   = req_pc;
          m_inst[d] = err ? 32'h0 : ref_mem[req_pc[5:2]];
        end else if (v && rsp_ready) begin
          pend[d] = 1'b0;
        end
      end
    end
    if (ld_en) ref_mem[ld_addr] = ld_data;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] pc, input logic rr, input logic fl,
                               input logic le, input logic [AW-1:0] la, input logic [31:0] ldv);
    req_valid = rv;
    req_pc    = pc;
    rsp_ready = rr;
    flush     = fl;
    ld_en     = le;
    ld_addr   = la;
    ld_data   = ldv;
  endtask

  task automatic idle(input logic rr);
    applyStimulus(1'b0, 32'h0, rr, 1'b0, 1'b0, '0, 32'h0);
  endtask

  // One clock: compare every instance with the model mid-cycle, then advance the model on the edge.
  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < N_DUT; d++) begin
      obs_ready[d] = o_ready[d];
      obs_valid[d] = o_valid[d];
      obs_err[d]   = o_err[d];
      obs_inst[d]  = o_inst[d];
      obs_pc[d]    = o_pc[d];
      checkOutput($sformatf("d%0d_req_ready", d), 32'(o_ready[d]), 32'(expReady(d)));
      checkOutput($sformatf("d%0d_rsp_valid", d), 32'(o_valid[d]), 32'(expValid(d)));
      if (expValid(d)) begin
        checkOutput($sformatf("d%0d_rsp_inst", d), o_inst[d], m_inst[d]);
        checkOutput($sformatf("d%0d_rsp_pc", d), o_pc[d], m_pc[d]);
        checkOutput($sformatf("d%0d_rsp_err", d), 32'(o_err[d]), 32'(m_err[d]));
      end
    end
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      cycle();
    end
  endtask

  // Waits for instance d to raise rsp_valid; returns cycles since the accept, or -1 on timeout.
  task automatic waitValid(input int d, input logic rr, output int seen);
    seen = -1;
    for (int k = 1; k <= 10; k++) begin
      idle(rr);
      cycle();
      if (obs_valid[d] === 1'b1) begin
        seen = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        rr;
    logic        fl;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_err;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int seen;
    int spurious;
    logic [31:0] rpc;

    // Zero-latency instance: streaming, error codes, backpressure and a flush cycle.
    vecs[0]  = '{1'b1, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,  1'b0};
    vecs[1]  = '{1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h00000013, 32'h0,  1'b0};
    vecs[2]  = '{1'b1, 32'h8,  1'b1, 1'b0, 1'b1, 1'b1, 32'h00100093, 32'h4,  1'b0};
    vecs[3]  = '{1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 1'b1, 32'h00200113, 32'h8,  1'b0};
    vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h00308193, 32'hC,  1'b0};
    vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,  1'b0};
    vecs[6]  = '{1'b1, 32'h6,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,  1'b0};
    vecs[7]  = '{1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h6,  1'b1};
    vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h6,  1'b1};
    vecs[9]  = '{1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        32'h6,  1'b1};
    vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        32'h40, 1'b1};
    vecs[11] = '{1'b1, 32'h4,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,  1'b0};
    vecs[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,  1'b0};

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
    modelClear();

    idle(1'b0);
    #2 rst_n = 1'b0;
    modelClear();
    cycle();
    for (int d = 0; d < N_DUT; d++) begin
      checkOutput($sformatf("reset_d%0d_valid", d), 32'(obs_valid[d]), 32'h0);
      checkOutput($sformatf("reset_d%0d_inst", d), obs_inst[d], 32'h0);
      checkOutput($sformatf("reset_d%0d_pc", d), obs_pc[d], 32'h0);
      checkOutput($sformatf("reset_d%0d_err", d), 32'(obs_err[d]), 32'h0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        0:       applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, AW'(i), 32'h00000013);
        1:       applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, AW'(i), 32'h00100093);
        2:       applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, AW'(i), 32'h00200113);
        3:       applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, AW'(i), 32'h00308193);
        default: applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, AW'(i), $urandom);
      endcase
      cycle();
    end

    $display("[TB] table vectors on the zero-latency instance");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rv, vecs[i].pc, vecs[i].rr, vecs[i].fl, 1'b0, '0, 32'h0);
      cycle();
      checkOutput($sformatf("vec%0d_ready", i), 32'(obs_ready[0]), 32'(vecs[i].e_ready));
      checkOutput($sformatf("vec%0d_valid", i), 32'(obs_valid[0]), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        checkOutput($sformatf("vec%0d_inst", i), obs_inst[0], vecs[i].e_inst);
        checkOutput($sformatf("vec%0d_pc", i), obs_pc[0], vecs[i].e_pc);
        checkOutput($sformatf("vec%0d_err", i), 32'(obs_err[0]), 32'(vecs[i].e_err));
      end
    end
    drain();

    $display("[TB] basic fetch and backpressure on LATENCY=2");
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    cycle();
    waitValid(1, 1'b0, seen);
    checkOutput("basic_latency", 32'(seen), 32'd3);
    checkOutput("basic_inst", obs_inst[1], 32'h00100093);
    checkOutput("basic_pc", obs_pc[1], 32'h4);
    for (int k = 0; k < 5; k++) begin
      idle(1'b0);
      cycle();
      checkOutput("bp_ready", 32'(obs_ready[1]), 32'h0);
      checkOutput("bp_valid", 32'(obs_valid[1]), 32'h1);
      checkOutput("bp_inst", obs_inst[1], 32'h00100093);
    end
    idle(1'b1);
    cycle();
    idle(1'b1);
    cycle();
    checkOutput("bp_valid_drop", 32'(obs_valid[1]), 32'h0);
    drain();

    $display("[TB] flush on LATENCY=3");
    spurious = 0;
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, '0, 32'h0);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, '0, 32'h0);
    cycle();
    if (obs_valid[2] !== 1'b0) spurious++;
    idle(1'b1);
    cycle();
    if (obs_valid[2] !== 1'b0) spurious++;
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, '0, 32'h0);
    cycle();
    if (obs_valid[2] !== 1'b0) spurious++;
    waitValid(2, 1'b1, seen);
    checkOutput("flush_no_response", 32'(spurious), 32'h0);
    checkOutput("flush_next_latency", 32'(seen), 32'd4);
    checkOutput("flush_next_inst", obs_inst[2], 32'h00200113);
    checkOutput("flush_next_pc", obs_pc[2], 32'h8);
    drain();

    $display("[TB] load colliding with accept");
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 1'b1, AW'(1), 32'hDEADBEEF);
    cycle();
    waitValid(1, 1'b1, seen);
    checkOutput("collide_old_word", obs_inst[1], 32'h00100093);
    drain();
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, '0, 32'h0);
    cycle();
    waitValid(1, 1'b1, seen);
    checkOutput("collide_new_word", obs_inst[1], 32'hDEADBEEF);
    drain();

    $display("[TB] reset during wait states");
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    cycle();
    idle(1'b0);
    cycle();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < N_DUT; d++) begin
      checkOutput($sformatf("midreset_d%0d_valid", d), 32'(o_valid[d]), 32'h0);
      checkOutput($sformatf("midreset_d%0d_inst", d), o_inst[d], 32'h0);
      checkOutput($sformatf("midreset_d%0d_pc", d), o_pc[d], 32'h0);
    end
    modelClear();
    cycle();
    rst_n = 1'b1;
    idle(1'b0);
    cycle();
    checkOutput("postreset_idle_ready", 32'(obs_ready[2]), 32'h1);
    checkOutput("postreset_valid", 32'(obs_valid[2]), 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       rpc = ($urandom | 32'h40) & ~32'h3;
        1:       rpc = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        default: rpc = 32'($urandom_range(0, 15)) << 2;
      endcase
      applyStimulus(1'($urandom_range(0, 1)), rpc, ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                    AW'($urandom_range(0, 15)), $urandom);
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
